// File: rtl/uart_rx_parity_if.sv
// uart_rx_parity_if: serial input and received-byte outputs of the parity UART receiver.
interface uart_rx_parity_if;
  logic       i_Rx_Serial;
  logic       o_Rx_Dv;
  logic [7:0] o_Rx_Byte;
  logic       o_Parity_Err;
  logic       o_Frame_Err;
  logic       o_Rx_Active;
  modport master (
    input  i_Rx_Serial,
    output o_Rx_Dv, o_Rx_Byte, o_Parity_Err, o_Frame_Err, o_Rx_Active
  );
  modport slave (
    output i_Rx_Serial,
    input  o_Rx_Dv, o_Rx_Byte, o_Parity_Err, o_Frame_Err, o_Rx_Active
  );
endinterface

// File: rtl/uart_rx_parity.sv
// uart_rx_parity: 8E1 UART receiver, mid-bit sampling, even-parity and framing error reporting.
module uart_rx_parity #(
  parameter int CLK_CY_PER_BIT = 87
) (
  input logic               i_clk,
  input logic               i_rst_n,
  uart_rx_parity_if.master  rx
);
  localparam int CW = $clog2(CLK_CY_PER_BIT);
  localparam logic [CW-1:0] FULL = CW'(CLK_CY_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'((CLK_CY_PER_BIT - 1) / 2);
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_CLEANUP, S_BREAK} state_t;
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    data_q, data_d, byte_q, byte_d;
  logic          par_q, par_d, perr_q, perr_d, dv_q, dv_d, ferr_q, ferr_d, act_q, act_d;
  logic          meta_q, rx_s_q;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      meta_q  <= 1'b1;
      rx_s_q  <= 1'b1;
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      par_q   <= 1'b0;
      byte_q  <= '0;
      perr_q  <= 1'b0;
      dv_q    <= 1'b0;
      ferr_q  <= 1'b0;
      act_q   <= 1'b0;
    end else begin
      meta_q  <= rx.i_Rx_Serial;
      rx_s_q  <= meta_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      par_q   <= par_d;
      byte_q  <= byte_d;
      perr_q  <= perr_d;
      dv_q    <= dv_d;
      ferr_q  <= ferr_d;
      act_q   <= act_d;
    end
  end
  // Strobes and the byte are registered on the transition into CLEANUP/BREAK so they line up with that state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    data_d  = data_q;
    par_d   = par_q;
    byte_d  = byte_q;
    perr_d  = perr_q;
    act_d   = act_q;
    dv_d    = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        idx_d = '0;
        if (!rx_s_q) begin
          state_d = S_START;
          act_d   = 1'b1;
        end
      end
      S_START: begin
        cnt_d = (cnt_q == HALF) ? '0 : cnt_q + 1'b1;
        if (cnt_q == HALF) begin
          state_d = rx_s_q ? S_IDLE : S_DATA;
          act_d   = !rx_s_q;
        end
      end
      S_DATA: begin
        cnt_d = (cnt_q == FULL) ? '0 : cnt_q + 1'b1;
        if (cnt_q == FULL) begin
          data_d[idx_q] = rx_s_q;
          idx_d         = idx_q + 3'd1;
          state_d       = (idx_q == 3'd7) ? S_PARITY : S_DATA;
        end
      end
      S_PARITY: begin
        cnt_d = (cnt_q == FULL) ? '0 : cnt_q + 1'b1;
        if (cnt_q == FULL) begin
          par_d   = rx_s_q;
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        cnt_d = (cnt_q == FULL) ? '0 : cnt_q + 1'b1;
        if (cnt_q == FULL) begin
          act_d   = 1'b0;
          state_d = rx_s_q ? S_CLEANUP : S_BREAK;
          dv_d    = rx_s_q;
          ferr_d  = !rx_s_q;
          byte_d  = rx_s_q ? data_q : byte_q;
          perr_d  = rx_s_q ? (^data_q) ^ par_q : perr_q;
        end
      end
      S_CLEANUP: state_d = S_IDLE;
      S_BREAK:   state_d = rx_s_q ? S_IDLE : S_BREAK;
      default:   state_d = S_IDLE;
    endcase
  end
  assign rx.o_Rx_Dv      = dv_q;
  assign rx.o_Rx_Byte    = byte_q;
  assign rx.o_Parity_Err = perr_q;
  assign rx.o_Frame_Err  = ferr_q;
  assign rx.o_Rx_Active  = act_q;
endmodule
